axis_oscilloscope_reader: RTL
=============================

AXIS_OSCILLOSCOPE_READER -- requirements
Module: axis_oscilloscope_reader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AXIS_TDATA_WIDTH  32  stream and BRAM data width
  BRAM_ADDR_WIDTH   12  BRAM address width; the buffer holds 2^BRAM_ADDR_WIDTH words
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  aclk            in   1       clock
  aresetn         in   1       reset, synchronous, active-low
  run_flag        in   1       level request to start one readout
  trg_addr        in   BRAM_ADDR_WIDTH   trigger sample address in the capture buffer
  pre_data        in   BRAM_ADDR_WIDTH   pre-trigger sample count
  tot_data        in   BRAM_ADDR_WIDTH   readout length minus one
  sts_data        out  BRAM_ADDR_WIDTH+1 {words_sent, busy}
  bram_porta_clk  out  1       equals aclk
  bram_porta_addr out  BRAM_ADDR_WIDTH   read address
  bram_porta_rddata in AXIS_TDATA_WIDTH  read data, valid 1 cycle after address
  m_axis_tdata    out  AXIS_TDATA_WIDTH  sample
  m_axis_tvalid   out  1       sample valid
  m_axis_tready   in   1       downstream ready
  m_axis_tlast    out  1       last sample of the readout

Function
REQ-003 States SHALL be IDLE, READ, DRAIN and DONE.
REQ-004 IDLE with run_flag=1 SHALL latch start = (trg_addr - pre_data) mod 2^BRAM_ADDR_WIDTH and len = tot_data, clear words_sent, and enter READ on the next cycle.
REQ-005 Readout SHALL deliver exactly len+1 words, from addresses start, start+1, ..., in that order.
REQ-006 Address arithmetic SHALL be modulo 2^BRAM_ADDR_WIDTH: the address wraps from all-ones to 0 without a gap.
REQ-007 The BRAM read latency SHALL be treated as exactly 1 cycle.
REQ-008 Output buffering SHALL be a 2-entry FIFO.
REQ-009 In READ, a read SHALL be issued in a cycle only if (FIFO occupancy + reads in flight - pops this cycle) < 2.
REQ-010 Under sustained tready=1, throughput SHALL be one word per cycle.
REQ-011 Latency from the READ entry cycle to the first tvalid=1 SHALL be 2 cycles.
REQ-012 After the issue of read number len+1, the block SHALL enter DRAIN.
REQ-013 DRAIN SHALL enter DONE in the cycle after the tlast word is accepted (tvalid & tready).
REQ-014 DONE SHALL hold until run_flag=0, then return to IDLE; a held-high run_flag SHALL never retrigger a readout.
REQ-015 m_axis_tlast SHALL be 1 only on word number len+1.
REQ-016 When tot_data=0, the single word delivered SHALL carry tlast.
REQ-017 Once tvalid is asserted, tvalid and tdata SHALL stay stable until accepted.
REQ-018 tready=0 SHALL never cause a word to be lost or duplicated.
REQ-019 Changes on trg_addr, pre_data and tot_data outside IDLE SHALL be ignored.
REQ-020 run_flag falling outside DONE SHALL be ignored; the readout completes.
REQ-021 words_sent SHALL increment on each accepted beat and saturate at len+1.
REQ-022 busy SHALL equal 1 in READ and DRAIN, and 0 otherwise.
REQ-023 tot_data = 2^BRAM_ADDR_WIDTH-1 SHALL read the full buffer once.
  - words_sent then wraps to 0 at completion.
  - sts_data bit 0 (busy) distinguishes completion from idle.
REQ-024 bram_porta_addr SHALL hold its last value when no read is issued.

Reset
REQ-025 Under aresetn=0 sampled at a rising edge, the block SHALL enter IDLE.
  - m_axis_tvalid=0, m_axis_tlast=0, sts_data=0, bram_porta_addr=0
  - FIFO emptied, in-flight reads discarded
REQ-026 Reset mid-readout SHALL abort immediately, with no further beats.
REQ-027 After reset release, a readout SHALL start only on a new IDLE with run_flag=1.

Verification
REQ-028 Basic (width 12): BRAM[i]=i, trg_addr=100, pre_data=10, tot_data=7, tready=1, run_flag=1 -> data 90..97, tlast on 97, busy falls, sts_data words_sent=8.
REQ-029 Wrap: trg_addr=2, pre_data=5, tot_data=9 -> addresses 4093, 4094, 4095, 0, ..., 6 in order, no gap.
REQ-030 Backpressure: tready random 50% with BRAM[i]=i -> contiguous sequence, no loss or duplication, tdata stable while tvalid & ~tready.
REQ-031 Single word: tot_data=0 -> one beat with tlast=1, then DONE; run_flag held high -> no second readout until run_flag has been 0.
REQ-032 Reset mid-readout: aresetn low after 3 of 8 beats -> next cycle tvalid=0 and sts_data=0; a subsequent run restarts from the start address.
REQ-033 Throughput: tready=1 and tot_data=4095 -> 4096 beats in 4096 consecutive cycles, first beat 2 cycles after the READ entry cycle.

Source files
------------

// File: rtl/axis_oscilloscope_reader.sv
// rtl/axis_oscilloscope_reader.sv - streams a trigger-relative window of a capture BRAM out over AXI-Stream
module axis_oscilloscope_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH  = 12
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        run_flag,
    input  logic [BRAM_ADDR_WIDTH-1:0]  trg_addr,
    input  logic [BRAM_ADDR_WIDTH-1:0]  pre_data,
    input  logic [BRAM_ADDR_WIDTH-1:0]  tot_data,
    output logic [BRAM_ADDR_WIDTH:0]    sts_data,
    output logic                        bram_porta_clk,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);
    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = AXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_len;
    logic [AW-1:0]      r_next_addr;
    logic [AW-1:0]      r_last_addr;
    logic [AW-1:0]      r_words;
    logic [AW:0]        r_rd_cnt;
    logic               r_rd_valid;
    logic               r_rd_last;
    logic [1:0][DW-1:0] r_fifo_data;
    logic [1:0]         r_fifo_last;
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;

    logic               w_pop;
    logic               w_issue;
    logic               w_rd_is_last;
    logic [2:0]         w_occ_after;

    // Occupancy seen by the issue gate counts the word already in flight from the BRAM.
    assign w_pop        = (r_count != 2'd0) && m_axis_tready;
    assign w_occ_after  = {1'b0, r_count} + {2'b00, r_rd_valid} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_READ) && (w_occ_after < 3'd2);
    assign w_rd_is_last = (r_rd_cnt == {1'b0, r_len});

    assign bram_porta_clk  = aclk;
    assign bram_porta_addr = w_issue ? r_next_addr : r_last_addr;

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_fifo_data[r_rptr];
    assign m_axis_tlast  = (r_count != 2'd0) && r_fifo_last[r_rptr];

    assign sts_data = {r_words, (r_state == S_READ) || (r_state == S_DRAIN)};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_next_addr <= '0;
            r_last_addr <= '0;
            r_words     <= '0;
            r_rd_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_fifo_data <= '0;
            r_fifo_last <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run_flag) begin
                        r_next_addr <= trg_addr - pre_data;
                        r_len       <= tot_data;
                        r_words     <= '0;
                        r_rd_cnt    <= '0;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_next_addr <= r_next_addr + 1'b1;
                        r_last_addr <= r_next_addr;
                        r_rd_cnt    <= r_rd_cnt + 1'b1;
                        if (w_rd_is_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && r_fifo_last[r_rptr]) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (!run_flag) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase

            r_rd_valid <= w_issue;
            r_rd_last  <= w_issue && w_rd_is_last;

            if (r_rd_valid) begin
                r_fifo_data[r_wptr] <= bram_porta_rddata;
                r_fifo_last[r_wptr] <= r_rd_last;
                r_wptr              <= ~r_wptr;
            end
            // Only len+1 beats are ever produced, so the count stops there on its own.
            if (w_pop) begin
                r_rptr  <= ~r_rptr;
                r_words <= r_words + 1'b1;
            end
            r_count <= r_count + {1'b0, r_rd_valid} - {1'b0, w_pop};
        end
    end
endmodule
